// File: rtl/fx3_pkg.sv
// Shared FX3 project definitions: streaming FSM encoding and default packet/latency geometry.
package fx3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        GAP    = 2'd3
    } fx3_state_e;

    localparam int FX3_PACKET_WORDS = 8192;
    localparam int FX3_READ_LATENCY = 2;
    localparam int FX3_SKID_DEPTH   = 4;
    localparam int FX3_WORD_W       = 16;
    localparam int FX3_CNT_W        = 13;

endpackage

// File: rtl/fx3_skid_fifo.sv
// Small single-clock FIFO that catches FIFO words still in flight when the FX3 bus stalls.
module fx3_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fx3_packet_transmitter.sv
// Streams fixed-size packets from the sample FIFO to the FX3 bus with valid/ready flow control.
// fx3Data/fx3Valid form a valid/ready source: a word moves when fx3Valid && fx3Ready, and holds until then.
module fx3_packet_transmitter
    import fx3_pkg::*;
#(
    parameter int PACKET_WORDS = FX3_PACKET_WORDS,
    parameter int READ_LATENCY = FX3_READ_LATENCY,
    parameter int SKID_DEPTH   = FX3_SKID_DEPTH
) (
    input  logic        fx3Clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        dataAvailable,
    input  logic [15:0] fifoData,
    input  logic        fx3Ready,
    output logic        readData,
    output logic [15:0] fx3Data,
    output logic        fx3Valid,
    output logic        fx3PacketEnd,
    output logic [15:0] packetCount,
    output logic        busy,
    output logic [1:0]  dbgState
);

    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W      = $clog2(SKID_DEPTH + READ_LATENCY + 1) + 1;
    localparam logic [FX3_CNT_W-1:0] LAST_WORD = FX3_CNT_W'(PACKET_WORDS - 1);

    fx3_state_e                state_q, state_d;
    logic [FX3_CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [FX3_CNT_W-1:0]      sent_cnt_q, sent_cnt_d;
    logic [15:0]               packet_count_q, packet_count_d;
    logic [READ_LATENCY-1:0]   pipe_q, pipe_d;

    logic [SKID_CNT_W-1:0]     skid_count;
    logic [15:0]               skid_head;
    logic [OCC_W-1:0]          inflight;
    logic [OCC_W-1:0]          occupancy;
    logic                      read_req;
    logic                      xfer;
    logic                      last_word;

    // The oldest strobe is counted even while it is being pushed; keeping occupancy + inflight
    // within SKID_DEPTH means every in-flight word always has a free slot when fx3Ready drops.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
        occupancy = OCC_W'(skid_count) + inflight;
        read_req  = !reset && (state_q == STREAM) && fx3Ready && (occupancy < OCC_W'(SKID_DEPTH));
        xfer      = fx3Valid && fx3Ready;
        last_word = (sent_cnt_q == LAST_WORD);
    end

    always_comb begin
        state_d        = state_q;
        rd_cnt_d       = rd_cnt_q;
        sent_cnt_d     = sent_cnt_q;
        packet_count_d = packet_count_q;
        pipe_d         = '0;
        pipe_d[0]      = read_req;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (read_req) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (xfer) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (enable && dataAvailable && fx3Ready) begin
                    state_d    = STREAM;
                    rd_cnt_d   = '0;
                    sent_cnt_d = '0;
                end
            end
            STREAM: begin
                if (read_req && (rd_cnt_q == LAST_WORD)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && last_word) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d        = IDLE;
                packet_count_d = packet_count_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fx3Clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rd_cnt_q       <= '0;
            sent_cnt_q     <= '0;
            packet_count_q <= '0;
            pipe_q         <= '0;
        end else begin
            state_q        <= state_d;
            rd_cnt_q       <= rd_cnt_d;
            sent_cnt_q     <= sent_cnt_d;
            packet_count_q <= packet_count_d;
            pipe_q         <= pipe_d;
        end
    end

    fx3_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (16)
    ) u_skid (
        .clk       (fx3Clk),
        .reset     (reset),
        .push      (pipe_q[READ_LATENCY-1]),
        .push_data (fifoData),
        .pop       (xfer),
        .head_data (skid_head),
        .count     (skid_count)
    );

    // Outputs are forced quiet combinationally so they read zero from the first reset cycle.
    assign readData     = read_req;
    assign fx3Valid     = !reset && (skid_count != '0);
    assign fx3Data      = reset ? 16'h0000 : skid_head;
    assign fx3PacketEnd = fx3Valid && last_word && (state_q == FLUSH);
    assign packetCount  = reset ? 16'h0000 : packet_count_q;
    assign busy         = !reset && (state_q != IDLE);
    assign dbgState     = state_q;

endmodule

// File: tb/tb_fx3_packet_transmitter.sv
// Self-checking bench for fx3_packet_transmitter: FIFO source model, scoreboard queue, directed packet scenarios.
module tb_fx3_packet_transmitter;
    import fx3_pkg::*;

    localparam int PW = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        dataAvailable;
    logic [15:0] fifoData;
    logic        fx3Ready;
    logic        readData;
    logic [15:0] fx3Data;
    logic        fx3Valid;
    logic        fx3PacketEnd;
    logic [15:0] packetCount;
    logic        busy;
    logic [1:0]  dbgState;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    // Shared bookkeeping between the monitor and the main sequence.
    int          cyc = 0;
    int          word_idx = 0;
    int          pkt_done = 0;
    int          rd_total = 0;
    int          rd_while_low = 0;
    int          hold_viol = 0;
    int          xfer_total = 0;
    int          first_rd_cyc = -1;
    int          first_vld_cyc = -1;
    int          end_cyc = 0;
    int          last_pkt_words = 0;
    logic [15:0] src_val = 16'd0;
    logic [15:0] cur_word = 16'hDEAD;
    logic [15:0] hold_data = 16'hDEAD;
    logic        ready_toggle = 1'b0;
    int          phase = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;

    always #5 clk = ~clk;

    fx3_packet_transmitter dut (
        .fx3Clk        (clk),
        .reset         (reset),
        .enable        (enable),
        .dataAvailable (dataAvailable),
        .fifoData      (fifoData),
        .fx3Ready      (fx3Ready),
        .readData      (readData),
        .fx3Data       (fx3Data),
        .fx3Valid      (fx3Valid),
        .fx3PacketEnd  (fx3PacketEnd),
        .packetCount   (packetCount),
        .busy          (busy),
        .dbgState      (dbgState)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FIFO source: the word for a read in cycle t is on fifoData throughout cycle t+2.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fifoData  = hold_data;
            hold_data = cur_word;
            if (ready_toggle) begin
                fx3Ready = (phase == 0);
                phase    = (phase + 1) % 4;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                word_idx   = 0;
                cur_word   = 16'hDEAD;
                prev_stall = 1'b0;
                continue;
            end
            if (readData) begin
                rd_total++;
                if (!fx3Ready) rd_while_low++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                cur_word = src_val;
                exp_q.push_back(src_val);
                src_val = src_val + 16'd1;
            end else begin
                cur_word = 16'hDEAD;
            end
            if (fx3Valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (prev_stall && !(fx3Valid && fx3Data == prev_data)) hold_viol++;
            if (fx3PacketEnd && !fx3Valid) hold_viol++;
            prev_stall = fx3Valid && !fx3Ready;
            prev_data  = fx3Data;
            if (fx3Valid && fx3Ready) begin
                xfer_total++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", fx3Data, 16'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word_data", fx3Data, e);
                end
                check_eq("packet_end", fx3PacketEnd, (word_idx == PW - 1));
                if (fx3PacketEnd) begin
                    pkt_done++;
                    last_pkt_words = word_idx + 1;
                    end_cyc        = cyc;
                    word_idx       = 0;
                end else begin
                    word_idx++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        src_val       = 16'd0;
        first_rd_cyc  = -1;
        first_vld_cyc = -1;
        rd_total      = 0;
        rd_while_low  = 0;
        hold_viol     = 0;
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 200 && !busy; i++) tick(1);
        check_eq(tag, busy, 1'b1);
    endtask

    task automatic wait_pkts(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && pkt_done < target; i++) tick(1);
        check_eq(tag, pkt_done, target);
    endtask

    task automatic wait_word(input string tag, input int idx, input int budget);
        for (int i = 0; i < budget && word_idx < idx; i++) tick(1);
        check_eq(tag, (word_idx >= idx), 1'b1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_readData"}, readData, 1'b0);
        check_eq({tag, "_fx3Valid"}, fx3Valid, 1'b0);
        check_eq({tag, "_fx3PacketEnd"}, fx3PacketEnd, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_fx3Data"}, fx3Data, 16'h0000);
        check_eq({tag, "_packetCount"}, packetCount, 16'd0);
        check_eq({tag, "_state"}, dbgState, IDLE);
    endtask

    initial begin
        int snap_rd;
        int snap_xfer;
        int busy_seen;
        int vld_seen;

        reset         = 1'b1;
        enable        = 1'b0;
        dataAvailable = 1'b0;
        fx3Ready      = 1'b0;
        fifoData      = 16'h0;
        tick(5);
        check_quiet("reset");
        reset = 1'b0;
        tick(2);

        // Full-rate packet.
        start_test();
        fx3Ready      = 1'b1;
        enable        = 1'b1;
        dataAvailable = 1'b1;
        wait_busy("t1_start");
        dataAvailable = 1'b0;
        wait_pkts("t1_done", 1, 9000);
        tick(3);
        check_eq("t1_packetCount", packetCount, 16'd1);
        check_eq("t1_idle", busy, 1'b0);
        check_eq("t1_words", last_pkt_words, PW);
        check_eq("t1_reads", rd_total, PW);
        check_eq("t1_first_latency", first_vld_cyc - first_rd_cyc, 3);
        check_eq("t1_throughput", end_cyc - first_vld_cyc, PW - 1);
        check_eq("t1_leftover", exp_q.size(), 0);

        // Ready toggling 1 high / 3 low.
        start_test();
        phase         = 0;
        ready_toggle  = 1'b1;
        dataAvailable = 1'b1;
        wait_busy("t2_start");
        dataAvailable = 1'b0;
        wait_pkts("t2_done", 2, 40000);
        ready_toggle = 1'b0;
        fx3Ready     = 1'b1;
        tick(3);
        check_eq("t2_packetCount", packetCount, 16'd2);
        check_eq("t2_words", last_pkt_words, PW);
        check_eq("t2_reads", rd_total, PW);
        check_eq("t2_read_while_not_ready", rd_while_low, 0);
        check_eq("t2_hold_stable", hold_viol, 0);
        check_eq("t2_leftover", exp_q.size(), 0);

        // Enable dropped mid-packet; dataAvailable stays high.
        start_test();
        dataAvailable = 1'b1;
        wait_busy("t3_start");
        wait_word("t3_word4000", 4000, 5000);
        enable = 1'b0;
        wait_pkts("t3_done", 3, 9000);
        tick(3);
        check_eq("t3_packetCount", packetCount, 16'd3);
        check_eq("t3_words", last_pkt_words, PW);
        snap_rd   = rd_total;
        busy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (busy) busy_seen++;
        end
        check_eq("t3_stay_idle", busy_seen, 0);
        check_eq("t3_no_reads", rd_total - snap_rd, 0);

        // Reset pulsed mid-packet.
        start_test();
        enable = 1'b1;
        wait_busy("t4_start");
        dataAvailable = 1'b0;
        wait_word("t4_word5000", 5000, 6000);
        reset  = 1'b1;
        enable = 1'b0;
        tick(1);
        check_quiet("t4_reset");
        reset     = 1'b0;
        snap_xfer = xfer_total;
        vld_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (fx3Valid) vld_seen++;
        end
        check_eq("t4_no_stale_valid", vld_seen, 0);
        check_eq("t4_no_stale_xfer", xfer_total - snap_xfer, 0);
        check_eq("t4_packetCount", packetCount, 16'd0);

        // Data available but bus not ready, then counter wrap on the next packet.
        start_test();
        fx3Ready      = 1'b0;
        enable        = 1'b1;
        dataAvailable = 1'b1;
        snap_rd       = rd_total;
        busy_seen     = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (busy) busy_seen++;
        end
        check_eq("t6_busy_while_not_ready", busy_seen, 0);
        check_eq("t6_no_reads", rd_total - snap_rd, 0);
        force dut.packet_count_q = 16'hFFFF;
        tick(2);
        release dut.packet_count_q;
        tick(1);
        check_eq("t5_preload", packetCount, 16'hFFFF);
        fx3Ready = 1'b1;
        check_eq("t6_still_idle", busy, 1'b0);
        tick(1);
        check_eq("t6_busy_next", busy, 1'b1);
        check_eq("t6_stream_next", dbgState, STREAM);
        dataAvailable = 1'b0;
        wait_pkts("t5_done", 4, 9000);
        tick(3);
        check_eq("t5_wrap", packetCount, 16'd0);
        check_eq("t5_words", last_pkt_words, PW);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fx3_packet_transmitter.md
FX3_PACKET_TRANSMITTER -- requirements
Module: fx3_packet_transmitter

Interface
REQ-001 The block SHALL have a single clock, fx3Clk (input, 1 bit, FX3 interface clock), on whose rising edge all logic is clocked.
REQ-002 The block SHALL have reset (input, 1 bit), a synchronous, active-high reset sampled on the rising edge of fx3Clk.
REQ-003 The block SHALL have PACKET_WORDS, default 8192, the number of 16-bit words per USB packet.
REQ-004 The block SHALL have READ_LATENCY, default 2, the number of fx3Clk cycles from readData high to the matching fifoData word (FIFO output register plus sample-conversion register).
REQ-005 The block SHALL have SKID_DEPTH, default 4, the output buffer depth in words; it SHALL be at least READ_LATENCY+2.
REQ-006 The block SHALL have enable (input, 1 bit), high while data collection is active.
REQ-007 The block SHALL have dataAvailable (input, 1 bit), high when the sample FIFO holds at least PACKET_WORDS words.
REQ-008 The block SHALL have fifoData (input, 16 bits), the signed sample word returned READ_LATENCY cycles after readData.
REQ-009 The block SHALL have fx3Ready (input, 1 bit), high when the FX3 DMA buffer accepts a word this cycle.
REQ-010 The block SHALL have readData (output, 1 bit), the FIFO read request, one word per high cycle.
REQ-011 The block SHALL have fx3Data (output, 16 bits), the word presented to the FX3 bus.
REQ-012 The block SHALL have fx3Valid (output, 1 bit), high when fx3Data holds a valid word.
REQ-013 The block SHALL have fx3PacketEnd (output, 1 bit), high together with the last word of a packet.
REQ-014 The block SHALL have packetCount (output, 16 bits), the number of completed packets.
REQ-015 The block SHALL have busy (output, 1 bit), high in every state except IDLE.

Function
REQ-016 A word SHALL transfer on any cycle where fx3Valid and fx3Ready are both high; fx3Data and fx3Valid SHALL hold steady until that transfer.
REQ-017 The state machine SHALL have four states: IDLE, STREAM, FLUSH and GAP.
REQ-018 The state SHALL move IDLE->STREAM when enable, dataAvailable and fx3Ready are all high in the same cycle.
REQ-019 The state SHALL move STREAM->FLUSH in the cycle the PACKET_WORDS-th read is issued.
REQ-020 The state SHALL move FLUSH->GAP on the transfer of the word marked with fx3PacketEnd.
REQ-021 The state SHALL move GAP->IDLE after exactly 1 cycle.
REQ-022 In STREAM, readData SHALL be high only when fx3Ready is high and (skid occupancy + reads in flight) < SKID_DEPTH.
REQ-023 readData SHALL never be high outside STREAM.
REQ-024 With fx3Ready held high, throughput SHALL be 1 word per cycle after the initial latency.
REQ-025 The first fx3Valid of a packet SHALL appear READ_LATENCY+1 cycles after the first readData.
REQ-026 When fx3Ready goes low, reads SHALL stop and every in-flight word SHALL be captured in the skid buffer, with no loss or duplication, and then delivered in FIFO order.
REQ-027 The read counter SHALL be 13 bits wide and the sent-word counter 13 bits wide, both cleared on IDLE->STREAM.
REQ-028 fx3PacketEnd SHALL be high only with sent word index PACKET_WORDS-1.
REQ-029 A packet, once started, SHALL be atomic: deassertion of enable mid-packet SHALL NOT truncate it, and the packet SHALL complete normally.
REQ-030 A new packet SHALL NOT start when enable is low.
REQ-031 packetCount SHALL increment by 1 in GAP and SHALL wrap from 65535 to 0.
REQ-032 When dataAvailable is high and fx3Ready is low in IDLE, the block SHALL remain in IDLE with no reads issued.
REQ-033 Changes on dataAvailable during STREAM or FLUSH SHALL be ignored.

Reset
REQ-034 While reset is high, the state SHALL be IDLE, the counters and skid buffer SHALL be cleared, and readData, fx3Valid, fx3PacketEnd and busy SHALL all be 0.
REQ-035 While reset is high, fx3Data SHALL be 16'h0000 and packetCount SHALL be 0.
REQ-036 Reset asserted mid-packet SHALL abandon that packet immediately; in-flight FIFO words arriving after reset SHALL be discarded.
REQ-037 No output SHALL depend on reset state beyond the cycle after reset falls.

Structure
REQ-038 The state encoding, PACKET_WORDS and READ_LATENCY defaults SHALL live in the shared project package (fx3_pkg) for reuse by the FX3 GPIF and test-data modules.
REQ-039 The skid buffer SHALL be a separate sub-module, fx3_skid_fifo (synchronous FIFO with SKID_DEPTH entries, count output, single clock).
REQ-040 The top level SHALL contain only the state machine, the counters and the in-flight pipeline tracker (a READ_LATENCY-deep shift register of read strobes).

Verification
REQ-041 The bench SHALL check: fx3Ready constantly 1, dataAvailable 1, fifoData counting from 0 -> 8192 transfers with values 0..8191, fx3PacketEnd only on 8191, packetCount=1, and 8192 readData cycles.
REQ-042 The bench SHALL check: fx3Ready toggling 1 cycle high / 3 cycles low throughout the packet -> the full contiguous sequence with no gap or repeat, and readData never high while fx3Ready is low.
REQ-043 The bench SHALL check: enable dropped at word 4000 -> the packet completes to word 8191, after which the block stays in IDLE while enable=0.
REQ-044 The bench SHALL check: reset pulsed at word 5000 -> outputs 0 next cycle, packetCount=0, and no stale words appear after reset falls.
REQ-045 The bench SHALL check: 65536 packets run (or packetCount preloaded via force to 65535) -> packetCount wraps to 0.
REQ-046 The bench SHALL check: dataAvailable=1 with fx3Ready=0 for 100 cycles -> busy=0 and no reads; fx3Ready rising -> STREAM starts next cycle.
